// File: rtl/seq_bit_tx.sv
`default_nettype none
// ============================================================================
//  Module      : seq_bit_tx
//  Description : Serial bit-stream transmitter. Accepts WIDTH-bit words over
//                a valid/ready handshake and shifts them out MSB-first, one bit
//                per clock. An optional fixed run of zero gap bits can follow
//                each word. A reference count of overlapping "101" patterns
//                seen on its own output is kept alongside.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_bit_tx #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               data_valid,
    output logic               data_ready,
    output logic               d,
    output logic               d_valid,
    output logic               busy,
    output logic [CNT_W-1:0]   pat_count
);

    localparam int c_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [c_CW-1:0] c_BIT_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic            c_NO_GAP   = (GAP_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_CW-1:0]    r_bit_cnt;
    logic [c_GW-1:0]    r_gap_cnt;
    logic [1:0]         r_hist;
    logic [CNT_W-1:0]   r_pat;

    logic               w_last_bit;
    logic               w_last_gap;
    logic               w_accept;

    // Handshake decode: ready in IDLE, on the final word bit when no gap is
    // configured, and on the final gap bit otherwise.
    always_comb begin
        w_last_bit = (r_state == S_SHIFT) && (r_bit_cnt == c_BIT_LAST);
        w_last_gap = (r_state == S_GAP) && (r_gap_cnt == c_GAP_LAST);
        data_ready = (r_state == S_IDLE) || (w_last_bit && c_NO_GAP) || w_last_gap;
        w_accept   = data_valid && data_ready;
    end

    // The serial bit is the MSB of the shift register. After a full word has
    // been shifted out the register is all zeros, so IDLE and GAP drive 0.
    assign d         = r_shift[WIDTH-1];
    assign busy      = (r_state != S_IDLE);
    assign d_valid   = (r_state != S_IDLE);
    assign pat_count = r_pat;

    // Transmit FSM, shift register and "101" reference counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_hist    <= 2'b00;
            r_pat     <= '0;
        end else begin
            // History tracks every driven bit, idle zeros included, so the
            // count matches a detector that samples on every clock.
            r_hist <= {r_hist[0], r_shift[WIDTH-1]};
            if ((r_hist == 2'b10) && r_shift[WIDTH-1]) begin
                r_pat <= r_pat + CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= data_in;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + c_CW'(1);
                    if (r_bit_cnt == c_BIT_LAST) begin
                        if (!c_NO_GAP) begin
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end else if (w_accept) begin
                            // Back-to-back reload keeps the stream continuous.
                            r_shift   <= data_in;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state   <= S_IDLE;
                        end
                    end
                end

                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + c_GW'(1);
                    if (r_gap_cnt == c_GAP_LAST) begin
                        if (w_accept) begin
                            r_shift   <= data_in;
                            r_bit_cnt <= '0;
                            r_state   <= S_SHIFT;
                        end else begin
                            r_state   <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_bit_tx.md
Name: seq_bit_tx

Overview:
Serial bit-stream transmitter that drives the single-bit `d` input of the serial "101" sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, with an optional fixed run of zero gap bits after each word. It also keeps a reference count of overlapping "101" occurrences on its own output, so a bench can compare the detector's `detected` pulses against it.

Parameters:
WIDTH, 8, bits per transmitted word (>=2)
GAP_CYCLES, 0, zero bits driven after each word before the next word may start (>=0)
CNT_W, 16, width of the pattern-occurrence counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
data_in  input  WIDTH  word to transmit, MSB sent first
data_valid  input  1  data_in holds a valid word
data_ready  output  1  block can accept a word this cycle
d  output  1  serial bit (registered), connects to detector `d`
d_valid  output  1  d carries a word bit or gap bit (high in SHIFT/GAP)
busy  output  1  high when state is SHIFT or GAP
pat_count  output  CNT_W  overlapping "101" occurrences emitted on d since reset

Behaviour:
- One clock, clk. rst is synchronous and active-high: on a rising edge with rst=1, all state resets and no handshake is accepted.
- Values after reset: state IDLE, d=0, d_valid=0, busy=0, data_ready=1, pat_count=0, shift register=0, bit counter=0, history=2'b00.
- Accept: a word is accepted on a rising edge where data_valid=1 and data_ready=1. data_in is captured into the shift register. data_in is ignored at every other edge.
- States:
  - IDLE: d=0, d_valid=0, data_ready=1. On accept, go to SHIFT.
  - SHIFT: d = current MSB, d_valid=1. Shift left one bit per cycle. Bit counter runs 0..WIDTH-1.
    - Last bit with GAP_CYCLES=0: data_ready=1. On accept, reload and stay in SHIFT. Otherwise go to IDLE.
    - Last bit with GAP_CYCLES>0: go to GAP. data_ready=0 in this cycle.
  - GAP: d=0, d_valid=1 for exactly GAP_CYCLES cycles.
    - data_ready=1 only in the final gap cycle. On accept, go to SHIFT. Otherwise go to IDLE.
- Latency: word accepted at edge k. Its MSB appears on d in the cycle after edge k. Its LSB appears WIDTH-1 cycles later.
- Back-to-back, GAP_CYCLES=0: a word accepted on the last-bit cycle gives a continuous stream with no idle bit between words.
- busy = (state != IDLE). d_valid equals busy.
- Pattern counter:
  - A 2-bit history register holds the previous two values of d. It updates every cycle after reset, including IDLE zeros, so it matches what a detector sampling every clock sees.
  - pat_count increments by 1 at the edge where history == 2'b10 and d == 1.
  - Occurrences overlap: 10101 counts 2.
  - Occurrences across word boundaries and across gap/idle bits count.
  - pat_count wraps modulo 2^CNT_W.
- Reset mid-word: the rest of the word is discarded, pat_count clears, and outputs return to reset values on the next cycle.
- data_valid held while data_ready=0: no capture and no state change. Changes on data_in have no effect.

Test Plan:
1. Assert rst for 2 cycles, then release -> d=0, d_valid=0, busy=0, data_ready=1, pat_count=0.
2. GAP_CYCLES=0, accept 8'hA0 -> d = 1,0,1,0,0,0,0,0 on the 8 cycles after accept. pat_count=1 after the 3rd bit. Then IDLE, d_valid=0, data_ready=1.
3. GAP_CYCLES=0, 8'hAA then 8'h55 presented back-to-back with data_valid held -> data_ready=1 on bit 8 of the first word. 16 continuous bits 1010101001010101. pat_count=6.
4. Boundary across words:
   - GAP_CYCLES=0, 8'h02 then 8'h80 -> the ...1,0 | 1 boundary yields pat_count=1.
   - GAP_CYCLES=2, same words -> stream ...1,0,0,0,1,... gives pat_count=0, and data_ready is high only in the 2nd gap cycle.
5. data_valid=1 while busy, with data_in toggling every cycle -> only the word presented on a ready cycle is transmitted. The bit sequence is unaffected.
6. rst asserted on the 3rd bit of 8'hA5 -> next cycle d=0, d_valid=0, busy=0, data_ready=1, pat_count=0. Remaining bits are never driven.
